// File: rtl/fifo_reg_master.sv
// Bus initiator for the FIFO control/status registers: runs write/read/poll commands as bus accesses.
// Define FIFO_REG_MASTER_TIMEOUT_EN to bound polls by POLL_TIMEOUT reads; otherwise polls run until match.
module fifo_reg_master #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 32,
    parameter int POLL_GAP     = 4,
    parameter int POLL_TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [DATA_W-1:0] cmd_mask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic              wen,
    output logic              ren,
    input  logic              ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_GAP,
        S_RESP
    } state_t;

    localparam logic [1:0] OP_WR   = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_ILL  = 2'b11;
    localparam int         GAP_W   = $clog2(POLL_GAP + 1);

    if (POLL_GAP < 1 || POLL_TIMEOUT < 1) begin : g_bad_param
        $error("fifo_reg_master: POLL_GAP and POLL_TIMEOUT must be >= 1");
    end

    state_t            state;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] exp_q;
    logic [DATA_W-1:0] mask_q;
    logic [GAP_W-1:0]  gap_cnt;

`ifdef FIFO_REG_MASTER_TIMEOUT_EN
    localparam int                PCNT_W     = $clog2(POLL_TIMEOUT + 1);
    localparam logic [PCNT_W-1:0] POLL_LIMIT = PCNT_W'(POLL_TIMEOUT);
    logic [PCNT_W-1:0] poll_cnt;
`endif

    function automatic logic poll_match(input logic [DATA_W-1:0] data,
                                        input logic [DATA_W-1:0] expv,
                                        input logic [DATA_W-1:0] mask);
        return (data & mask) == (expv & mask);
    endfunction

    // Poll compare operands only matter while a poll runs, so they carry no reset.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && cmd_valid && cmd_ready) begin
            exp_q  <= cmd_wdata;
            mask_q <= cmd_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            wen       <= 1'b0;
            ren       <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            op_q      <= OP_WR;
            gap_cnt   <= '0;
`ifdef FIFO_REG_MASTER_TIMEOUT_EN
            poll_cnt  <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        op_q      <= cmd_op;
`ifdef FIFO_REG_MASTER_TIMEOUT_EN
                        poll_cnt  <= '0;
`endif
                        if (cmd_op == OP_ILL) begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            state <= S_ACCESS;
                            addr  <= cmd_addr;
                            wen   <= (cmd_op == OP_WR);
                            ren   <= (cmd_op != OP_WR);
                            wdata <= (cmd_op == OP_WR) ? cmd_wdata : '0;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end

                // Strobe, addr and wdata stay put until the bus signals ready.
                S_ACCESS: begin
                    if (ready) begin
                        wen <= 1'b0;
                        ren <= 1'b0;
                        case (op_q)
                            OP_WR: begin
                                rsp_rdata <= '0;
                                rsp_err   <= 1'b0;
                                rsp_valid <= 1'b1;
                                state     <= S_RESP;
                            end
                            OP_RD: begin
                                rsp_rdata <= rdata;
                                rsp_err   <= 1'b0;
                                rsp_valid <= 1'b1;
                                state     <= S_RESP;
                            end
                            default: begin
                                rsp_rdata <= rdata;
`ifdef FIFO_REG_MASTER_TIMEOUT_EN
                                poll_cnt  <= poll_cnt + PCNT_W'(1);
`endif
                                if (poll_match(rdata, exp_q, mask_q)) begin
                                    rsp_err   <= 1'b0;
                                    rsp_valid <= 1'b1;
                                    state     <= S_RESP;
                                end
`ifdef FIFO_REG_MASTER_TIMEOUT_EN
                                else if (poll_cnt + PCNT_W'(1) == POLL_LIMIT) begin
                                    rsp_err   <= 1'b1;
                                    rsp_valid <= 1'b1;
                                    state     <= S_RESP;
                                end
`endif
                                else begin
                                    gap_cnt <= GAP_W'(POLL_GAP - 1);
                                    state   <= S_GAP;
                                end
                            end
                        endcase
                    end
                end

                // Counts POLL_GAP-1 down to 0: exactly POLL_GAP idle cycles.
                S_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= S_ACCESS;
                        ren   <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end

                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_reg_master.sv
// Directed bench for fifo_reg_master against a small register-block model (0x04 reads as status=1).
module tb_fifo_reg_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [31:0] cmd_mask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        wen;
    logic        ren;
    logic        bus_ready;

    logic [31:0] mem [0:63];
    int n_chk = 0;
    int n_err = 0;
    int cyc = 0, wen_hi = 0, strobes = 0, ren_done = 0, rsp_cnt = 0, both_hi = 0;
    int last_ren_cyc = 0, prev_ren_cyc = 0;

    fifo_reg_master #(
        .ADDR_W(8), .DATA_W(32), .POLL_GAP(4), .POLL_TIMEOUT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .addr(addr), .wdata(wdata), .rdata(rdata), .wen(wen), .ren(ren), .ready(bus_ready)
    );

    always #5 clk = ~clk;

    assign rdata = (addr == 8'h04) ? 32'h0000_0001 : mem[addr[7:2]];

    always @(posedge clk) begin
        cyc++;
        if (wen) wen_hi++;
        if (wen || ren) strobes++;
        if (wen && ren) both_hi++;
        if (wen && bus_ready) mem[addr[7:2]] = wdata;
        if (ren && bus_ready) begin
            prev_ren_cyc = last_ren_cyc;
            last_ren_cyc = cyc;
            ren_done++;
        end
        if (rsp_valid && rsp_ready) rsp_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] a,
                         input logic [31:0] d, input logic [31:0] m);
        for (int i = 0; i < 20 && !cmd_ready; i++) step();
        check("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_mask  = m;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int max);
        for (int i = 0; i < max && !rsp_valid; i++) step();
        check(tag, rsp_valid, 1);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, r0, c0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 8'h00;
        cmd_wdata = 32'h0; cmd_mask = 32'h0; rsp_ready = 1'b1; bus_ready = 1'b1;
        step(); step();
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_wen", wen, 0);
        check("rst_ren", ren, 0);
        check("rst_addr", addr, 0);
        check("rst_rsp_err", rsp_err, 0);
        rst = 1'b0;
        step();
        check("idle_cmd_ready", cmd_ready, 1);

        // Write 0x00 <- 0x1: strobe at N+1, response at N+2, cmd_ready back at N+3
        issue(2'b00, 8'h00, 32'h1, 32'h0);
        check("wr_wen", wen, 1);
        check("wr_ren", ren, 0);
        check("wr_addr", addr, 8'h00);
        check("wr_wdata", wdata, 32'h1);
        check("wr_cmd_ready", cmd_ready, 0);
        step();
        check("wr_rsp_valid", rsp_valid, 1);
        check("wr_rsp_err", rsp_err, 0);
        check("wr_rsp_rdata", rsp_rdata, 32'h0);
        check("wr_wen_drop", wen, 0);
        step();
        check("wr_rsp_done", rsp_valid, 0);
        check("wr_cmd_ready_back", cmd_ready, 1);

        // Read status 0x04
        r0 = ren_done;
        issue(2'b01, 8'h04, 32'hFFFF_FFFF, 32'h0);
        check("rd_ren", ren, 1);
        check("rd_wen", wen, 0);
        check("rd_addr", addr, 8'h04);
        check("rd_wdata", wdata, 32'h0);
        step();
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_rsp_rdata", rsp_rdata, 32'h1);
        check("rd_rsp_err", rsp_err, 0);
        check("rd_one_strobe", ren_done - r0, 1);
        step();

        // Bus ready low for 3 cycles during a write
        bus_ready = 1'b0;
        s0 = wen_hi;
        c0 = rsp_cnt;
        issue(2'b00, 8'h08, 32'hA5A5_0003, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check("stall_wen", wen, 1);
            check("stall_addr", addr, 8'h08);
            check("stall_wdata", wdata, 32'hA5A5_0003);
            check("stall_no_rsp", rsp_valid, 0);
            step();
        end
        check("stall_wen_last", wen, 1);
        bus_ready = 1'b1;
        step();
        check("stall_rsp_valid", rsp_valid, 1);
        check("stall_wen_cycles", wen_hi - s0, 4);
        step(); step();
        check("stall_one_rsp", rsp_cnt - c0, 1);

        // Response back-pressure: read 0x08 with rsp_ready low
        rsp_ready = 1'b0;
        issue(2'b01, 8'h08, 32'h0, 32'h0);
        step();
        s0 = strobes;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_rdata", rsp_rdata, 32'hA5A5_0003);
            check("bp_cmd_ready", cmd_ready, 0);
            step();
        end
        check("bp_no_strobe", strobes - s0, 0);
        rsp_ready = 1'b1;
        check("bp_still_valid", rsp_valid, 1);
        step();
        check("bp_rsp_done", rsp_valid, 0);
        check("bp_cmd_ready_back", cmd_ready, 1);

        // Illegal op: error response without bus access
        s0 = strobes;
        issue(2'b11, 8'h10, 32'h1234_5678, 32'h0);
        check("ill_rsp_valid", rsp_valid, 1);
        check("ill_rsp_err", rsp_err, 1);
        check("ill_rsp_rdata", rsp_rdata, 32'h0);
        check("ill_wen", wen, 0);
        check("ill_ren", ren, 0);
        step();
        check("ill_no_strobe", strobes - s0, 0);

        // Poll with mask 0 matches on the first read
        r0 = ren_done;
        issue(2'b10, 8'h04, 32'hFFFF_FFFF, 32'h0);
        wait_rsp("poll0_rsp", 40);
        check("poll0_err", rsp_err, 0);
        check("poll0_rdata", rsp_rdata, 32'h1);
        check("poll0_reads", ren_done - r0, 1);
        step();

        // Poll status bit 0 expecting 1: immediate match
        r0 = ren_done;
        issue(2'b10, 8'h04, 32'h1, 32'h1);
        wait_rsp("poll1_rsp", 40);
        check("poll1_err", rsp_err, 0);
        check("poll1_reads", ren_done - r0, 1);
        step();

`ifdef FIFO_REG_MASTER_TIMEOUT_EN
        // Poll expecting empty bit 0: four reads five cycles apart, then timeout
        r0 = ren_done;
        issue(2'b10, 8'h04, 32'h0, 32'h1);
        wait_rsp("pto_rsp", 60);
        check("pto_err", rsp_err, 1);
        check("pto_rdata", rsp_rdata, 32'h1);
        check("pto_reads", ren_done - r0, 4);
        check("pto_spacing", last_ren_cyc - prev_ren_cyc, 5);
        step();
        issue(2'b10, 8'h04, 32'h0, 32'h1);
`else
        // Without a timeout the mismatching poll keeps reading and never responds
        r0 = ren_done;
        c0 = rsp_cnt;
        issue(2'b10, 8'h04, 32'h0, 32'h1);
        for (int i = 0; i < 30; i++) step();
        check("pnt_no_rsp", rsp_cnt - c0, 0);
        check("pnt_reads_continue", (ren_done - r0) >= 5, 1);
        check("pnt_spacing", last_ren_cyc - prev_ren_cyc, 5);
`endif

        // Reset while the poll sits in its gap
        for (int i = 0; i < 20 && !ren; i++) step();
        for (int i = 0; i < 20 && ren; i++) step();
        check("gap_reached", ren, 0);
        check("gap_busy", cmd_ready, 0);
        check("gap_rdata_before", rsp_rdata, 32'h1);
        c0 = rsp_cnt;
        rst = 1'b1;
        step();
        check("grst_cmd_ready", cmd_ready, 0);
        check("grst_rsp_valid", rsp_valid, 0);
        check("grst_rsp_err", rsp_err, 0);
        check("grst_rsp_rdata", rsp_rdata, 32'h0);
        check("grst_wen", wen, 0);
        check("grst_ren", ren, 0);
        check("grst_addr", addr, 8'h00);
        check("grst_wdata", wdata, 32'h0);
        rst = 1'b0;
        s0 = strobes;
        for (int i = 0; i < 10; i++) step();
        check("grst_no_rsp", rsp_cnt - c0, 0);
        check("grst_no_strobe", strobes - s0, 0);
        check("grst_idle_ready", cmd_ready, 1);

        issue(2'b01, 8'h08, 32'h0, 32'h0);
        wait_rsp("post_rst_rsp", 10);
        check("post_rst_rdata", rsp_rdata, 32'hA5A5_0003);
        check("post_rst_err", rsp_err, 0);
        step();

        check("never_both_strobes", both_hi, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
